// File: rtl/matrix_host_if.sv
// Stream interface between the matrix host and the 2x2 complex multiplier.
// The host owns the master side: it drives the sample stream and receives results.
interface matrix_host_if #(
  parameter int DW_IN  = 7,
  parameter int DW_OUT = 9
);
  logic                     mx_in_valid;
  logic signed [DW_IN-1:0]  mx_in_real;
  logic signed [DW_IN-1:0]  mx_in_image;
  logic                     mx_out_valid;
  logic signed [DW_OUT-1:0] mx_out_real;
  logic signed [DW_OUT-1:0] mx_out_image;
  logic                     mx_busy;

  modport master (
    output mx_in_valid, mx_in_real, mx_in_image,
    input  mx_out_valid, mx_out_real, mx_out_image, mx_busy
  );

  modport slave (
    input  mx_in_valid, mx_in_real, mx_in_image,
    output mx_out_valid, mx_out_real, mx_out_image, mx_busy
  );
endinterface

// File: rtl/matrix_host.sv
// Host-side driver/collector for the 2x2 signed complex matrix multiplier.
// Holds eight samples (A in slots 0-3, B in slots 4-7), streams them as one
// gap-free frame on start, then gathers the four serial results c00..c11
// into a result bank with a per-result timeout.
module matrix_host #(
  parameter int DW_IN   = 7,
  parameter int DW_OUT  = 9,
  parameter int TIMEOUT = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ld_we,
  input  logic [2:0]               ld_addr,
  input  logic signed [DW_IN-1:0]  ld_real,
  input  logic signed [DW_IN-1:0]  ld_image,
  input  logic                     start,
  input  logic [1:0]               rd_addr,
  output logic signed [DW_OUT-1:0] rd_real,
  output logic signed [DW_OUT-1:0] rd_image,
  output logic                     host_busy,
  output logic                     done,
  output logic                     err,
  matrix_host_if.master            mx
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TMO_ONE  = TW'(1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SEND    = 3'd1,
    S_WAIT    = 3'd2,
    S_COLLECT = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t                   state_r;
  logic signed [DW_IN-1:0]  smp_real_r  [8];
  logic signed [DW_IN-1:0]  smp_image_r [8];
  logic signed [DW_OUT-1:0] res_real_r  [4];
  logic signed [DW_OUT-1:0] res_image_r [4];
  logic [2:0]               smp_cnt_r;
  logic [1:0]               res_cnt_r;
  logic [TW-1:0]            tmo_cnt_r;
  logic signed [DW_IN-1:0]  first_real_s;
  logic signed [DW_IN-1:0]  first_image_s;
  logic                     start_ok_s;

  // A start accepted together with a write to slot 0 must send the new value.
  always_comb begin
    first_real_s  = smp_real_r[0];
    first_image_s = smp_image_r[0];
    if (ld_we && (ld_addr == 3'd0)) begin
      first_real_s  = ld_real;
      first_image_s = ld_image;
    end else begin
      first_real_s  = smp_real_r[0];
      first_image_s = smp_image_r[0];
    end
  end

  assign start_ok_s = (state_r == S_IDLE) && start && !mx.mx_busy;

  // Result bank is read combinationally from its registers.
  assign rd_real  = res_real_r[rd_addr];
  assign rd_image = res_image_r[rd_addr];

  // Transfer FSM: sample bank, send stream, result capture, timeout and flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= S_IDLE;
      for (int i = 0; i < 8; i++) begin
        smp_real_r[i]  <= '0;
        smp_image_r[i] <= '0;
      end
      for (int i = 0; i < 4; i++) begin
        res_real_r[i]  <= '0;
        res_image_r[i] <= '0;
      end
      smp_cnt_r      <= 3'd0;
      res_cnt_r      <= 2'd0;
      tmo_cnt_r      <= '0;
      host_busy      <= 1'b0;
      done           <= 1'b0;
      err            <= 1'b0;
      mx.mx_in_valid <= 1'b0;
      mx.mx_in_real  <= '0;
      mx.mx_in_image <= '0;
    end else begin
      case (state_r)
        S_IDLE: begin
          done <= 1'b0;
          if (ld_we) begin
            smp_real_r[ld_addr]  <= ld_real;
            smp_image_r[ld_addr] <= ld_image;
          end
          if (start_ok_s) begin
            for (int i = 0; i < 4; i++) begin
              res_real_r[i]  <= '0;
              res_image_r[i] <= '0;
            end
            err            <= 1'b0;
            smp_cnt_r      <= 3'd0;
            res_cnt_r      <= 2'd0;
            host_busy      <= 1'b1;
            mx.mx_in_valid <= 1'b1;
            mx.mx_in_real  <= first_real_s;
            mx.mx_in_image <= first_image_s;
            state_r        <= S_SEND;
          end else begin
            host_busy      <= 1'b0;
            mx.mx_in_valid <= 1'b0;
            mx.mx_in_real  <= '0;
            mx.mx_in_image <= '0;
          end
        end
        S_SEND: begin
          // smp_cnt_r is the slot currently on the bus; preload the next one.
          if (smp_cnt_r == 3'd7) begin
            mx.mx_in_valid <= 1'b0;
            mx.mx_in_real  <= '0;
            mx.mx_in_image <= '0;
            tmo_cnt_r      <= '0;
            state_r        <= S_WAIT;
          end else begin
            mx.mx_in_valid <= 1'b1;
            mx.mx_in_real  <= smp_real_r[smp_cnt_r + 3'd1];
            mx.mx_in_image <= smp_image_r[smp_cnt_r + 3'd1];
            smp_cnt_r      <= smp_cnt_r + 3'd1;
          end
        end
        S_WAIT, S_COLLECT: begin
          // A capture always wins over an expiring timeout in the same cycle.
          if (mx.mx_out_valid) begin
            res_real_r[res_cnt_r]  <= mx.mx_out_real;
            res_image_r[res_cnt_r] <= mx.mx_out_image;
            res_cnt_r              <= res_cnt_r + 2'd1;
            tmo_cnt_r              <= '0;
            if (res_cnt_r == 2'd3) begin
              done    <= 1'b1;
              state_r <= S_DONE;
            end else begin
              state_r <= S_COLLECT;
            end
          end else if (tmo_cnt_r == TMO_LAST) begin
            err     <= 1'b1;
            done    <= 1'b1;
            state_r <= S_DONE;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + TMO_ONE;
          end
        end
        S_DONE: begin
          done      <= 1'b0;
          host_busy <= 1'b0;
          state_r   <= S_IDLE;
        end
        default: begin
          done           <= 1'b0;
          host_busy      <= 1'b0;
          mx.mx_in_valid <= 1'b0;
          mx.mx_in_real  <= '0;
          mx.mx_in_image <= '0;
          state_r        <= S_IDLE;
        end
      endcase
    end
  end

endmodule
